// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter with drain interrupt.
// Define UART_TX_PARITY_EN for 8E1 framing (even-parity bit after data).
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_write,
  input  logic [7:0] cpu_write_byte,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       tx_done_int,
  output logic       uart_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          out_d, done_d;
  logic          pop, push, empty, bit_end;
  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign empty   = (wptr_q == rptr_q);
  assign tx_full = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign tx_busy = (state_q != IDLE) || !empty;
  assign head    = mem[rptr_q[AW-1:0]];
  assign bit_end = (cnt_q == LAST);
  // A pop frees a slot in the same cycle, so a write while full still lands.
  assign push    = cpu_write && (!tx_full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = head;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  // Line level follows the next state so uart_out is a clean register.
  always_comb begin
    out_d = 1'b1;
    unique case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_d = par_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      uart_out    <= 1'b1;
      tx_done_int <= 1'b0;
      tx_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      uart_out    <= out_d;
      tx_done_int <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (cpu_write && !push) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= cpu_write_byte;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed checks of uart_tx against a
// frame-level model (byte queue plus frame start/end cycles).
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_write_byte = 8'h00;
  logic       tx_full, tx_busy, tx_overflow, tx_done_int, uart_out;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .cpu_write(cpu_write),
    .cpu_write_byte(cpu_write_byte),
    .tx_full(tx_full),
    .tx_busy(tx_busy),
    .tx_overflow(tx_overflow),
    .tx_done_int(tx_done_int),
    .uart_out(uart_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int scyc;

  // Model state: queued bytes, current frame span, pending interrupt.
  logic [7:0] q[$];
  logic [7:0] cur;
  int fs = -100;
  int fe = -100;
  int done_at = -1;
  logic ovf = 1'b0;

  // obs/exp = {uart_out, tx_done_int, tx_busy, tx_full, tx_overflow}
  logic [4:0] obs, exp;

  function automatic logic line_bit(input int c);
    int k;
    if (c < fs || c > fe) return 1'b1;
    k = (c - fs) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    if (k == 9 && NBITS == 11) return ^cur;
    return 1'b1;
  endfunction

  task automatic tick(input logic w, input logic [7:0] b,
                      input logic r);
    logic pop, acc;
    @(negedge clk);
    scyc = cyc;
    obs = {uart_out, tx_done_int, tx_busy, tx_full, tx_overflow};
    exp = {line_bit(cyc), done_at == cyc,
           (cyc >= fs && cyc <= fe) || q.size() > 0,
           q.size() == DEPTH, ovf};
    cpu_write = w;
    cpu_write_byte = b;
    rst = r;
    if (r) begin
      q.delete();
      fs = -100;
      fe = -100;
      done_at = -1;
      ovf = 1'b0;
    end else begin
      pop = q.size() > 0 && cyc >= fe;
      if (cyc == fe && !pop) done_at = cyc + 1;
      acc = w && (q.size() < DEPTH || pop);
      if (w && !acc) ovf = 1'b1;
      if (pop) begin
        cur = q.pop_front();
        fs = cyc + 1;
        fe = cyc + FRAME;
      end
      if (acc) q.push_back(b);
    end
    cyc++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", obs, 5'b10000);
    end
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_model got=%b want=%b", obs, exp);
    end
  endtask

  task automatic test_single;
    int n, first_low, dcnt, dcyc;
    logic busy_at_done;
    tick(1'b1, 8'hA5, 1'b0);
    n = scyc;
    first_low = -1;
    dcnt = 0;
    dcyc = -1;
    busy_at_done = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
      if (obs[4] === 1'b0 && first_low < 0) first_low = scyc;
      if (obs[3] === 1'b1) begin
        dcnt++;
        dcyc = scyc;
        busy_at_done = obs[2];
      end
    end
    total++;
    if (first_low !== n + 2) begin
      bad++;
      $display("FAIL single_latency got=%0d want=%0d", first_low, n + 2);
    end
    total++;
    if (dcnt !== 1 || dcyc !== n + 2 + FRAME) begin
      bad++;
      $display("FAIL single_int got=%0d@%0d want=1@%0d",
               dcnt, dcyc, n + 2 + FRAME);
    end
    total++;
    if (busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_fall got=%b want=0", busy_at_done);
    end
  endtask

  task automatic test_back_to_back;
    int n, dcnt, high_cnt;
    tick(1'b1, 8'h00, 1'b0);
    n = scyc;
    tick(1'b1, 8'hFF, 1'b0);
    dcnt = 0;
    high_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
      if (obs[3] === 1'b1) dcnt++;
      if (scyc >= n + 2 + FRAME - CPB && scyc < n + 2 + FRAME + CPB &&
          obs[4] === 1'b1) high_cnt++;
    end
    total++;
    if (dcnt !== 1) begin
      bad++;
      $display("FAIL b2b_int got=%0d want=1", dcnt);
    end
    total++;
    if (high_cnt !== CPB) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=%0d", high_cnt, CPB);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 8'(i), 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ovf_fill cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
    end
    tick(1'b0, 8'h00, 1'b0);
    total++;
    if (obs[1:0] !== 2'b11) begin
      bad++;
      $display("FAIL ovf_flags got=%b want=11", obs[1:0]);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ovf_drain cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
    end
    total++;
    if (obs[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", obs[0]);
    end
  endtask

  task automatic test_reset_mid;
    int n, dcnt, lowc;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h3C, 1'b0);
    n = scyc;
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'h55, 1'b0);
    while (cyc < n + 19) tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    dcnt = 0;
    lowc = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rstmid cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
      if (obs[3] === 1'b1) dcnt++;
      if (obs[4] !== 1'b1 || obs[2] !== 1'b0) lowc++;
    end
    total++;
    if (dcnt !== 0 || lowc !== 0) begin
      bad++;
      $display("FAIL rstmid_idle int=%0d active=%0d want=0/0", dcnt, lowc);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes [2];
    logic want;
    int n;
    bytes[0] = 8'h07;
    bytes[1] = 8'h03;
    for (int t = 0; t < 2; t++) begin
      tick(1'b1, bytes[t], 1'b0);
      n = scyc;
      want = (t == 0);
      for (int i = 0; i < FRAME + 6; i++) begin
        tick(1'b0, 8'h00, 1'b0);
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL parity cyc=%0d got=%b want=%b", scyc, obs, exp);
        end
        if (scyc == n + 2 + 9 * CPB + 1) begin
          total++;
          if (obs[4] !== want) begin
            bad++;
            $display("FAIL parity_bit got=%b want=%b", obs[4], want);
          end
        end
        if (scyc == n + 2 + FRAME) begin
          total++;
          if (obs[3] !== 1'b1) begin
            bad++;
            $display("FAIL parity_len got=%b want=1", obs[3]);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random;
    logic w;
    for (int i = 0; i < 2500; i++) begin
      w = ($urandom_range(0, 99) < (i < 1200 ? 8 : 30));
      tick(w, 8'($urandom), 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", scyc, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    tick(1'b0, 8'h00, 1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
